// File: rtl/axi_line_refill.sv
// Cache-line refill sequencer: one AXI INCR burst per line fill, beats assembled into a line.
// Only one refill is outstanding at a time. Beats seen outside DATA, or carrying a foreign
// ID, are dropped and flagged on stray_o one cycle later.
module axi_line_refill #(
  parameter int unsigned AxiNumWords = 4,
  parameter int unsigned AxiIdWidth  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [63:0]                 req_addr_i,
  input  logic [AxiIdWidth-1:0]       req_id_i,
  output logic                        rd_req_o,
  input  logic                        rd_gnt_i,
  output logic [63:0]                 rd_addr_o,
  output logic [$clog2(AxiNumWords)-1:0] rd_blen_o,
  output logic [1:0]                  rd_size_o,
  output logic [AxiIdWidth-1:0]       rd_id_o,
  output logic                        rd_lock_o,
  output logic                        rd_rdy_o,
  input  logic                        rd_valid_i,
  input  logic                        rd_last_i,
  input  logic [63:0]                 rd_data_i,
  input  logic [AxiIdWidth-1:0]       rd_id_i,
  output logic                        line_valid_o,
  input  logic                        line_ready_i,
  output logic [63:0]                 line_addr_o,
  output logic [AxiIdWidth-1:0]       line_id_o,
  output logic [AxiNumWords*64-1:0]   line_data_o,
  output logic                        line_err_o,
  output logic                        stray_o
);

  localparam int unsigned CntW = $clog2(AxiNumWords);
  localparam int unsigned OffW = $clog2(AxiNumWords * 8);
  localparam logic [CntW-1:0] LastCnt = CntW'(AxiNumWords - 1);

  typedef enum logic [1:0] {StIdle, StReq, StData, StOut} state_e;

  state_e                            state_q;
  logic [63:0]                       addr_q;
  logic [AxiIdWidth-1:0]             id_q;
  logic [CntW-1:0]                   cnt_q;
  logic [AxiNumWords-1:0][63:0]      words_q;
  logic                              err_q;
  logic                              stray_q;
  logic                              req_ready_q;
  logic                              rd_req_q;
  logic                              line_valid_q;
  logic                              beat_ok;
  logic                              cnt_last;

  // Beat qualification: only beats of the current burst while collecting data.
  always_comb begin
    beat_ok  = rd_valid_i && (state_q == StData) && (rd_id_i == id_q);
    cnt_last = (cnt_q == LastCnt);
  end

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      words_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      rd_req_q     <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            addr_q      <= {req_addr_i[63:OffW], OffW'(0)};
            id_q        <= req_id_i;
            cnt_q       <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rd_req_q    <= 1'b1;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (rd_gnt_i) begin
            rd_req_q <= 1'b0;
            state_q  <= StData;
          end
        end
        StData: begin
          if (beat_ok) begin
            words_q[cnt_q] <= rd_data_i;
            if (rd_last_i || cnt_last) begin
              // Early last or missing last both flag the line; cnt is frozen so it never wraps.
              err_q        <= rd_last_i ^ cnt_last;
              line_valid_q <= 1'b1;
              state_q      <= StOut;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StOut: begin
          if (line_ready_i) begin
            line_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stray beat flag, one cycle after the dropped beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stray_q <= 1'b0;
    end else begin
      stray_q <= rd_valid_i && !beat_ok;
    end
  end

  // Output mapping; burst attributes are constants.
  always_comb begin
    req_ready_o  = req_ready_q;
    rd_req_o     = rd_req_q;
    rd_addr_o    = addr_q;
    rd_blen_o    = LastCnt;
    rd_size_o    = 2'b11;
    rd_id_o      = id_q;
    rd_lock_o    = 1'b0;
    rd_rdy_o     = 1'b1;
    line_valid_o = line_valid_q;
    line_addr_o  = addr_q;
    line_id_o    = id_q;
    line_data_o  = words_q;
    line_err_o   = err_q;
    stray_o      = stray_q;
  end

endmodule

// File: tb/tb_axi_line_refill.sv
// Directed bench for axi_line_refill: one task per scenario with inline checks.
module tb_axi_line_refill;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [63:0]  req_addr = '0;
  logic [3:0]   req_id = '0;
  logic         rd_req;
  logic         rd_gnt = 1'b0;
  logic [63:0]  rd_addr;
  logic [1:0]   rd_blen;
  logic [1:0]   rd_size;
  logic [3:0]   rd_id_out;
  logic         rd_lock;
  logic         rd_rdy;
  logic         rd_valid = 1'b0;
  logic         rd_last = 1'b0;
  logic [63:0]  rd_data = '0;
  logic [3:0]   rd_id_in = '0;
  logic         line_valid;
  logic         line_ready = 1'b0;
  logic [63:0]  line_addr;
  logic [3:0]   line_id;
  logic [255:0] line_data;
  logic         line_err;
  logic         stray;

  int checks = 0;
  int failures = 0;

  logic [63:0] d [4];
  logic [255:0] exp_line;

  axi_line_refill #(.AxiNumWords(4), .AxiIdWidth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_id_i(req_id),
    .rd_req_o(rd_req), .rd_gnt_i(rd_gnt), .rd_addr_o(rd_addr), .rd_blen_o(rd_blen),
    .rd_size_o(rd_size), .rd_id_o(rd_id_out), .rd_lock_o(rd_lock), .rd_rdy_o(rd_rdy),
    .rd_valid_i(rd_valid), .rd_last_i(rd_last), .rd_data_i(rd_data), .rd_id_i(rd_id_in),
    .line_valid_o(line_valid), .line_ready_i(line_ready), .line_addr_o(line_addr),
    .line_id_o(line_id), .line_data_o(line_data), .line_err_o(line_err), .stray_o(stray)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [63:0] a, input logic [3:0] id);
    req_addr = a; req_id = id; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic grant;
    rd_gnt = 1'b1;
    tick;
    rd_gnt = 1'b0;
  endtask

  task automatic beat(input logic [63:0] dat, input logic [3:0] id, input logic last);
    rd_valid = 1'b1; rd_data = dat; rd_id_in = id; rd_last = last;
    tick;
    rd_valid = 1'b0; rd_last = 1'b0;
  endtask

  task automatic handshake;
    line_ready = 1'b1;
    tick;
    line_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (rd_rdy !== 1'b1) begin failures++; $display("FAIL rst_rd_rdy_during: got %b want 1", rd_rdy); end
    #20 rst_n = 1'b1;
    tick;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    checks++; if ({rd_req, line_valid, line_err, stray} !== 4'b0) begin failures++; $display("FAIL rst_flags: got %b want 0000", {rd_req, line_valid, line_err, stray}); end
    checks++; if (rd_addr !== 64'h0 || line_data !== 256'h0 || rd_id_out !== 4'h0) begin failures++; $display("FAIL rst_regs: addr %h data %h id %h want 0", rd_addr, line_data, rd_id_out); end
    checks++; if ({rd_blen, rd_size, rd_lock, rd_rdy} !== 6'b11_11_0_1) begin failures++; $display("FAIL rst_consts: got %b want 111101", {rd_blen, rd_size, rd_lock, rd_rdy}); end
  endtask

  task automatic test_basic;
    send_req(64'h8000_1234, 4'd3);
    checks++; if (rd_req !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL basic_req: rd_req %b req_ready %b want 1 0", rd_req, req_ready); end
    checks++; if (rd_addr !== 64'h8000_1220 || rd_id_out !== 4'd3) begin failures++; $display("FAIL basic_addr: got %h id %0d want 8000_1220 id 3", rd_addr, rd_id_out); end
    grant;
    checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL basic_req_drop: got %b want 0", rd_req); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL basic_early_line: beat %0d got %b want 0", i, line_valid); end
      beat(d[i], 4'd3, i == 3);
    end
    exp_line = {d[3], d[2], d[1], d[0]};
    checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL basic_line_valid: got %b want 1", line_valid); end
    checks++; if (line_data !== exp_line) begin failures++; $display("FAIL basic_data: got %h want %h", line_data, exp_line); end
    checks++; if (line_err !== 1'b0 || line_addr !== 64'h8000_1220 || line_id !== 4'd3) begin failures++; $display("FAIL basic_line_meta: err %b addr %h id %0d want 0 8000_1220 3", line_err, line_addr, line_id); end
    handshake;
    checks++; if (line_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL basic_done: valid %b ready %b want 0 1", line_valid, req_ready); end
  endtask

  task automatic test_grant_stall;
    send_req(64'h1000_0048, 4'd2);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rd_req !== 1'b1 || rd_addr !== 64'h1000_0040 || rd_id_out !== 4'd2 || line_valid !== 1'b0) begin
        failures++; $display("FAIL stall_hold: cyc %0d req %b addr %h id %0d lv %b want 1 1000_0040 2 0", i, rd_req, rd_addr, rd_id_out, line_valid); end
      tick;
    end
    rd_gnt = 1'b1;
    checks++; if (rd_req !== 1'b1) begin failures++; $display("FAIL stall_req_at_gnt: got %b want 1", rd_req); end
    tick;
    rd_gnt = 1'b0;
    checks++; if (rd_req !== 1'b0 || line_valid !== 1'b0) begin failures++; $display("FAIL stall_after_gnt: req %b lv %b want 0 0", rd_req, line_valid); end
    for (int i = 0; i < 4; i++) beat(d[i], 4'd2, i == 3);
    checks++; if (line_valid !== 1'b1 || line_data !== {d[3], d[2], d[1], d[0]}) begin failures++; $display("FAIL stall_line: lv %b data %h", line_valid, line_data); end
    handshake;
  endtask

  task automatic test_backpressure;
    send_req(64'h2000_00F8, 4'd1);
    grant;
    for (int i = 0; i < 4; i++) begin
      beat(d[3-i], 4'd1, i == 3);
      if (i < 3) for (int g = 0; g <= i; g++) tick;
    end
    exp_line = {d[0], d[1], d[2], d[3]};
    for (int i = 0; i < 4; i++) begin
      checks++; if (line_valid !== 1'b1 || line_data !== exp_line || line_addr !== 64'h2000_00E0 || req_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold: cyc %0d lv %b addr %h rr %b data %h want %h", i, line_valid, line_addr, req_ready, line_data, exp_line); end
      tick;
    end
    line_ready = 1'b1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_same_cycle: got %b want 0", req_ready); end
    tick;
    line_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || line_valid !== 1'b0) begin failures++; $display("FAIL bp_after_hs: rr %b lv %b want 1 0", req_ready, line_valid); end
  endtask

  task automatic test_stray;
    beat(64'hDEAD_0000_0000_0001, 4'd3, 1'b0);
    checks++; if (stray !== 1'b1) begin failures++; $display("FAIL stray_idle_pulse: got %b want 1", stray); end
    tick;
    checks++; if (stray !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL stray_idle_end: stray %b rr %b want 0 1", stray, req_ready); end
    send_req(64'h0000_0000_0000_0100, 4'd3);
    grant;
    beat(d[0], 4'd3, 1'b0);
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL stray_good_beat: got %b want 0", stray); end
    beat(64'hBAD0_BAD0_BAD0_BAD0, 4'd5, 1'b1);
    checks++; if (stray !== 1'b1 || line_valid !== 1'b0) begin failures++; $display("FAIL stray_foreign: stray %b lv %b want 1 0", stray, line_valid); end
    for (int i = 1; i < 4; i++) beat(d[i], 4'd3, i == 3);
    checks++; if (line_valid !== 1'b1 || line_err !== 1'b0 || line_data !== {d[3], d[2], d[1], d[0]}) begin
      failures++; $display("FAIL stray_line: lv %b err %b data %h", line_valid, line_err, line_data); end
    handshake;
  endtask

  task automatic test_error;
    send_req(64'h0000_0000_0000_0200, 4'd4);
    grant;
    beat(d[0], 4'd4, 1'b0);
    beat(d[1], 4'd4, 1'b1);
    exp_line = {64'h0, 64'h0, d[1], d[0]};
    checks++; if (line_valid !== 1'b1 || line_err !== 1'b1 || line_data !== exp_line) begin
      failures++; $display("FAIL err_early_last: lv %b err %b data %h want 1 1 %h", line_valid, line_err, line_data, exp_line); end
    handshake;
    send_req(64'h0000_0000_0000_0300, 4'd4);
    checks++; if (line_err !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b want 0", line_err); end
    grant;
    for (int i = 0; i < 4; i++) beat(d[i], 4'd4, 1'b0);
    checks++; if (line_valid !== 1'b1 || line_err !== 1'b1 || line_data !== {d[3], d[2], d[1], d[0]}) begin
      failures++; $display("FAIL err_no_last: lv %b err %b data %h", line_valid, line_err, line_data); end
    handshake;
  endtask

  task automatic test_reset_mid;
    send_req(64'h0000_0000_0000_0400, 4'd6);
    grant;
    beat(d[0], 4'd6, 1'b0);
    beat(d[1], 4'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || rd_req !== 1'b0 || line_valid !== 1'b0 || stray !== 1'b0 || line_err !== 1'b0) begin
      failures++; $display("FAIL midrst_flags: rr %b req %b lv %b stray %b err %b", req_ready, rd_req, line_valid, stray, line_err); end
    checks++; if (line_data !== 256'h0 || rd_addr !== 64'h0 || rd_id_out !== 4'h0 || rd_rdy !== 1'b1) begin
      failures++; $display("FAIL midrst_regs: data %h addr %h id %0d rdy %b", line_data, rd_addr, rd_id_out, rd_rdy); end
    #3 rst_n = 1'b1;
    tick;
    beat(d[2], 4'd6, 1'b0);
    checks++; if (stray !== 1'b1) begin failures++; $display("FAIL midrst_stray1: got %b want 1", stray); end
    beat(d[3], 4'd6, 1'b1);
    checks++; if (stray !== 1'b1 || line_valid !== 1'b0) begin failures++; $display("FAIL midrst_stray2: stray %b lv %b want 1 0", stray, line_valid); end
    tick;
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL midrst_stray_end: got %b want 0", stray); end
    send_req(64'hFFFF_FFFF_FFFF_FFFF, 4'd7);
    checks++; if (rd_addr !== 64'hFFFF_FFFF_FFFF_FFE0) begin failures++; $display("FAIL midrst_addr: got %h want FFFF_FFFF_FFFF_FFE0", rd_addr); end
    grant;
    for (int i = 0; i < 4; i++) beat(d[i] ^ 64'hF, 4'd7, i == 3);
    exp_line = {d[3] ^ 64'hF, d[2] ^ 64'hF, d[1] ^ 64'hF, d[0] ^ 64'hF};
    checks++; if (line_valid !== 1'b1 || line_err !== 1'b0 || line_data !== exp_line || line_id !== 4'd7) begin
      failures++; $display("FAIL midrst_next: lv %b err %b id %0d data %h want %h", line_valid, line_err, line_id, line_data, exp_line); end
    handshake;
  endtask

  initial begin
    d[0] = 64'h0123_4567_89AB_CDEF;
    d[1] = 64'h1111_2222_3333_4444;
    d[2] = 64'hA5A5_5A5A_F0F0_0F0F;
    d[3] = 64'hCAFE_BABE_DEAD_BEEF;
    test_reset;
    test_basic;
    test_grant_stall;
    test_backpressure;
    test_stray;
    test_error;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
